// File: rtl/ap_bank.sv
// Address pointer bank: eight AW-bit pointers with READ/LOAD/POSTINC/PREDEC.
// Optional sticky wrap flags per pointer when AP_OVF_EN is defined.
module ap_bank #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    APSel,
  input  logic          op_valid,
  input  logic [1:0]    op,
  input  logic [3:0]    step,
  input  logic [AW-1:0] load_data,
  output logic          op_ready,
  output logic [AW-1:0] addr_out,
  output logic          addr_valid,
  input  logic          addr_ready,
  output logic [AW-1:0] ap_cur,
  output logic [7:0]    ap_ovf
);

  logic [AW-1:0] ptr_q [8];
  logic [AW-1:0] ptr_d [8];
  logic [AW-1:0] addr_q, addr_d;
  logic          vld_q, vld_d;

  logic          accept;
  logic          is_rd, is_ld, is_inc, is_dec;
  logic [AW-1:0] cur;
  logic [AW:0]   step_w;
  logic [AW:0]   inc_w;
  logic [AW:0]   dec_w;

  assign op_ready   = !vld_q || addr_ready;
  assign accept     = op_valid && op_ready;
  assign addr_out   = addr_q;
  assign addr_valid = vld_q;

  assign cur    = ptr_q[APSel];
  assign ap_cur = cur;

  assign is_rd  = (op == 2'b00);
  assign is_ld  = (op == 2'b01);
  assign is_inc = (op == 2'b10);
  assign is_dec = (op == 2'b11);

  // Bit AW of the widened sums is the carry (inc) or borrow (dec).
  assign step_w = {{(AW-3){1'b0}}, step};
  assign inc_w  = {1'b0, cur} + step_w;
  assign dec_w  = {1'b0, cur} - step_w;

  // Next pointer/address state; nothing moves unless an op is accepted.
  always_comb begin
    ptr_d  = ptr_q;
    addr_d = addr_q;
    vld_d  = vld_q;
    if (accept) begin
      vld_d = 1'b1;
      unique case (1'b1)
        is_rd: addr_d = cur;
        is_ld: begin
          ptr_d[APSel] = load_data;
          addr_d       = load_data;
        end
        is_inc: begin
          ptr_d[APSel] = inc_w[AW-1:0];
          addr_d       = cur;
        end
        is_dec: begin
          ptr_d[APSel] = dec_w[AW-1:0];
          addr_d       = dec_w[AW-1:0];
        end
        default: addr_d = cur;
      endcase
    end else if (addr_ready) begin
      vld_d = 1'b0;
    end
  end

  // Pointer bank and one-entry output buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) ptr_q[i] <= '0;
      addr_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) ptr_q[i] <= ptr_d[i];
      addr_q <= addr_d;
      vld_q  <= vld_d;
    end
  end

`ifdef AP_OVF_EN
  logic [7:0] ovf_q, ovf_d;

  assign ap_ovf = ovf_q;

  // Sticky wrap flags: set on carry/borrow, cleared by LOAD.
  always_comb begin
    ovf_d = ovf_q;
    if (accept) begin
      unique case (1'b1)
        is_ld:  ovf_d[APSel] = 1'b0;
        is_inc: if (inc_w[AW]) ovf_d[APSel] = 1'b1;
        is_dec: if (dec_w[AW]) ovf_d[APSel] = 1'b1;
        default: ;
      endcase
    end
  end

  // Flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ovf_q <= '0;
    else      ovf_q <= ovf_d;
  end
`else
  logic unused_wrap;

  assign unused_wrap = ^{inc_w[AW], dec_w[AW]};
  assign ap_ovf      = 8'h00;
`endif

endmodule

// File: tb/tb_ap_bank.sv
// Directed testbench for ap_bank.
// Expected wrap flags depend on whether AP_OVF_EN is defined.
module tb_ap_bank;

  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    APSel;
  logic          op_valid;
  logic [1:0]    op;
  logic [3:0]    step;
  logic [AW-1:0] load_data;
  logic          op_ready;
  logic [AW-1:0] addr_out;
  logic          addr_valid;
  logic          addr_ready;
  logic [AW-1:0] ap_cur;
  logic [7:0]    ap_ovf;

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_LD  = 2'b01;
  localparam logic [1:0] OP_INC = 2'b10;
  localparam logic [1:0] OP_DEC = 2'b11;

`ifdef AP_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  ap_bank #(.AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .APSel      (APSel),
    .op_valid   (op_valid),
    .op         (op),
    .step       (step),
    .load_data  (load_data),
    .op_ready   (op_ready),
    .addr_out   (addr_out),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .ap_cur     (ap_cur),
    .ap_ovf     (ap_ovf)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    APSel = 3'd0; op_valid = 1'b0; op = OP_RD;
    step = 4'd0; load_data = '0; addr_ready = 1'b0;
    #3;
    checks++;
    if (addr_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%b exp=0", addr_valid);
    end
    checks++;
    if (addr_out !== 16'h0000) begin
      failures++;
      $display("FAIL reset_addr got=%h exp=0000", addr_out);
    end
    checks++;
    if (ap_ovf !== 8'h00) begin
      failures++;
      $display("FAIL reset_ovf got=%h exp=00", ap_ovf);
    end
    for (int i = 0; i < 8; i++) begin
      APSel = i[2:0];
      #1;
      checks++;
      if (ap_cur !== 16'h0000) begin
        failures++;
        $display("FAIL reset_ptr%0d got=%h exp=0000", i, ap_cur);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    checks++;
    if (op_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=1", op_ready);
    end
  endtask

  task automatic test_load;
    APSel = 3'd3; op = OP_LD; load_data = 16'h1234;
    op_valid = 1'b1; addr_ready = 1'b1;
    tick();
    op_valid = 1'b0;
    #1;
    checks++;
    if (addr_valid !== 1'b1 || addr_out !== 16'h1234) begin
      failures++;
      $display("FAIL load_addr got=%b/%h exp=1/1234",
               addr_valid, addr_out);
    end
    checks++;
    if (ap_cur !== 16'h1234) begin
      failures++;
      $display("FAIL load_ptr got=%h exp=1234", ap_cur);
    end
    tick();
    checks++;
    if (addr_valid !== 1'b0) begin
      failures++;
      $display("FAIL load_consume got=%b exp=0", addr_valid);
    end
  endtask

  task automatic test_postinc;
    APSel = 3'd2; op = OP_LD; load_data = 16'h0010;
    op_valid = 1'b1; addr_ready = 1'b1;
    tick();
    op = OP_INC; step = 4'd4;
    tick();
    checks++;
    if (addr_out !== 16'h0010 || addr_valid !== 1'b1) begin
      failures++;
      $display("FAIL postinc_1 got=%b/%h exp=1/0010",
               addr_valid, addr_out);
    end
    tick();
    op_valid = 1'b0;
    #1;
    checks++;
    if (addr_out !== 16'h0014 || addr_valid !== 1'b1) begin
      failures++;
      $display("FAIL postinc_2 got=%b/%h exp=1/0014",
               addr_valid, addr_out);
    end
    checks++;
    if (ap_cur !== 16'h0018) begin
      failures++;
      $display("FAIL postinc_ptr got=%h exp=0018", ap_cur);
    end
    tick();
  endtask

  task automatic test_predec;
    APSel = 3'd5; op = OP_LD; load_data = 16'h0002;
    op_valid = 1'b1; addr_ready = 1'b1;
    tick();
    op = OP_DEC; step = 4'd3;
    tick();
    checks++;
    if (addr_out !== 16'hFFFF || ap_cur !== 16'hFFFF) begin
      failures++;
      $display("FAIL predec got=%h/%h exp=FFFF/FFFF",
               addr_out, ap_cur);
    end
    checks++;
    if (ap_ovf !== (OVF ? 8'h20 : 8'h00)) begin
      failures++;
      $display("FAIL predec_ovf got=%h exp=%h",
               ap_ovf, OVF ? 8'h20 : 8'h00);
    end
    op = OP_INC; step = 4'd0;
    tick();
    checks++;
    if (addr_out !== 16'hFFFF || ap_cur !== 16'hFFFF
        || addr_valid !== 1'b1) begin
      failures++;
      $display("FAIL step0 got=%h/%h exp=FFFF/FFFF",
               addr_out, ap_cur);
    end
    op = OP_LD; load_data = 16'h0100;
    tick();
    op_valid = 1'b0;
    #1;
    checks++;
    if (ap_ovf !== 8'h00 || addr_out !== 16'h0100) begin
      failures++;
      $display("FAIL load_clr got=%h/%h exp=00/0100",
               ap_ovf, addr_out);
    end
    tick();
  endtask

  task automatic test_wrap;
    APSel = 3'd7; op = OP_LD; load_data = 16'hFFFE;
    op_valid = 1'b1; addr_ready = 1'b1;
    tick();
    op = OP_INC; step = 4'd3;
    tick();
    op_valid = 1'b0;
    #1;
    checks++;
    if (addr_out !== 16'hFFFE || ap_cur !== 16'h0001) begin
      failures++;
      $display("FAIL wrap got=%h/%h exp=FFFE/0001",
               addr_out, ap_cur);
    end
    checks++;
    if (ap_ovf !== (OVF ? 8'h80 : 8'h00)) begin
      failures++;
      $display("FAIL wrap_ovf got=%h exp=%h",
               ap_ovf, OVF ? 8'h80 : 8'h00);
    end
    tick();
  endtask

  task automatic test_stall;
    APSel = 3'd3; op = OP_RD; op_valid = 1'b1; addr_ready = 1'b0;
    tick();
    op = OP_INC; step = 4'd1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (op_ready !== 1'b0 || addr_out !== 16'h1234
          || ap_cur !== 16'h1234 || addr_valid !== 1'b1) begin
        failures++;
        $display("FAIL stall_%0d got=%b/%h/%h exp=0/1234/1234",
                 i, op_ready, addr_out, ap_cur);
      end
      tick();
    end
    addr_ready = 1'b1;
    #1;
    checks++;
    if (op_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_ready got=%b exp=1", op_ready);
    end
    tick();
    op_valid = 1'b0;
    #1;
    checks++;
    if (addr_valid !== 1'b1 || addr_out !== 16'h1234
        || ap_cur !== 16'h1235) begin
      failures++;
      $display("FAIL stall_release got=%b/%h/%h exp=1/1234/1235",
               addr_valid, addr_out, ap_cur);
    end
    tick();
    checks++;
    if (addr_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_drain got=%b exp=0", addr_valid);
    end
  endtask

  task automatic test_async_reset;
    APSel = 3'd7; op = OP_RD; op_valid = 1'b1; addr_ready = 1'b0;
    tick();
    op_valid = 1'b0;
    #1;
    checks++;
    if (addr_valid !== 1'b1) begin
      failures++;
      $display("FAIL arst_setup got=%b exp=1", addr_valid);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (addr_valid !== 1'b0 || ap_cur !== 16'h0000
        || ap_ovf !== 8'h00 || addr_out !== 16'h0000) begin
      failures++;
      $display("FAIL arst got=%b/%h/%h/%h exp=0/0000/0000/00",
               addr_valid, ap_cur, addr_out, ap_ovf);
    end
    APSel = 3'd3;
    #1;
    checks++;
    if (ap_cur !== 16'h0000) begin
      failures++;
      $display("FAIL arst_ptr3 got=%h exp=0000", ap_cur);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    checks++;
    if (op_ready !== 1'b1 || addr_valid !== 1'b0) begin
      failures++;
      $display("FAIL arst_release got=%b/%b exp=1/0",
               op_ready, addr_valid);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_postinc();
    test_predec();
    test_wrap();
    test_stall();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ap_bank.md
AP_BANK -- requirements
Module: ap_bank

Interface
REQ-001 SHALL have parameter AW, default 16, address pointer width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port APSel  input  3  pointer select from the AP stage, index 0..7.
REQ-005 SHALL have port op_valid  input  1  operation request.
REQ-006 SHALL have port op  input  2  opcode: 00 READ, 01 LOAD, 10 POSTINC, 11 PREDEC.
REQ-007 SHALL have port step  input  4  unsigned increment/decrement amount.
REQ-008 SHALL have port load_data  input  AW  value for LOAD.
REQ-009 SHALL have port op_ready  output  1  operation accepted this cycle when op_valid && op_ready.
REQ-010 SHALL have port addr_out  output  AW  registered effective address.
REQ-011 SHALL have port addr_valid  output  1  addr_out holds an unconsumed address.
REQ-012 SHALL have port addr_ready  input  1  downstream consumes addr_out when addr_valid && addr_ready.
REQ-013 SHALL have port ap_cur  output  AW  combinational view of pointer[APSel].
REQ-014 SHALL have port ap_ovf  output  8  per-pointer sticky wrap flags (see Configuration).

Function
REQ-015 SHALL hold eight AW-bit pointer registers, pointer[0..7].
REQ-016 SHALL drive op_ready = !addr_valid || addr_ready (one-entry output buffer, no bubble on streaming).
REQ-017 On accept, READ SHALL set addr_out <= pointer[APSel]; pointer unchanged.
REQ-018 On accept, LOAD SHALL set pointer[APSel] <= load_data and addr_out <= load_data.
REQ-019 On accept, POSTINC SHALL set addr_out <= pointer[APSel] and pointer[APSel] <= pointer[APSel] + step, modulo 2^AW.
REQ-020 On accept, PREDEC SHALL set pointer[APSel] <= pointer[APSel] - step and addr_out <= that new value, modulo 2^AW.
REQ-021 step = 0 SHALL leave the pointer unchanged for POSTINC/PREDEC while still producing an address.
REQ-022 addr_valid SHALL rise the cycle after accept (latency 1) and remain high until consumed.
REQ-023 On consume with no accept in the same cycle, addr_valid SHALL clear next edge.
REQ-024 On consume and accept in the same cycle, addr_valid SHALL stay high and addr_out SHALL take the new address.
REQ-025 While addr_valid && !addr_ready, addr_out SHALL hold stable and no pointer SHALL change.
REQ-026 Back-to-back ops on the same pointer SHALL see the value updated by the previous accepted op.
REQ-027 op_valid without accept SHALL have no side effect; APSel/op/step/load_data sampled only at accept.

Reset
REQ-028 rst low SHALL asynchronously clear all pointers, addr_out, addr_valid and ap_ovf to 0.
REQ-029 Reset mid-operation SHALL drop any pending address; op_ready SHALL be 1 after reset release.

Configuration
REQ-030 Macro AP_OVF_EN defined SHALL set ap_ovf[APSel] when an accepted POSTINC carries out of AW bits or PREDEC borrows, cleared only by LOAD to that pointer or reset.
REQ-031 Macro AP_OVF_EN undefined SHALL tie ap_ovf to 8'h00 with no flag registers.

Verification
REQ-032 Reset, LOAD APSel=3 data=0x1234, addr_ready=1 -> addr_valid next cycle, addr_out=0x1234, ap_cur(APSel=3)=0x1234.
REQ-033 pointer[2]=0x0010, POSTINC step=4 twice, addr_ready=1 -> addr_out 0x0010 then 0x0014, pointer[2]=0x0018.
REQ-034 pointer[5]=0x0002, PREDEC step=3 -> addr_out=0xFFFF, pointer[5]=0xFFFF; with AP_OVF_EN ap_ovf[5]=1, cleared by LOAD to pointer 5.
REQ-035 addr_ready=0 with addr_valid=1 for 3 cycles while op_valid=1 -> op_ready=0, addr_out and pointers unchanged; on addr_ready=1 the pending op is accepted same cycle.
REQ-036 rst asserted while addr_valid=1 -> addr_valid=0, all pointers 0x0000, ap_ovf=0 immediately, without a clock edge.
